// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo common data bus: schedule, result and broadcast formats.
package tomasulo_pkg;

    localparam int CDB_SCH_N = 8;
    localparam int TAG_W     = 6;
    localparam int WORD_W    = 32;
    localparam int CDB_ERR_W = 3;

    typedef logic [CDB_SCH_N-1:0] sch_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [WORD_W-1:0]    word_t;

    typedef struct packed {
        tag_t  tag;
        word_t wdata;
    } fu_res_t;

    typedef struct packed {
        logic  vld;
        tag_t  tag;
        word_t wdata;
    } cdb_t;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tomasulo_rr_arb.sv
// Generic N-way round-robin arbiter; the pointer moves past the winner when adv_en is high.
module tomasulo_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv_en,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] ptr_nxt_s;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // First requester at or after the pointer wins.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = PTR_W'((int'(ptr_r) + k) % N);
            if (req[idx_s] && !found_s) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer is one past the granted index.
    always_comb begin
        ptr_nxt_s = ptr_r;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                ptr_nxt_s = PTR_W'((i + 1) % N);
            end else begin
                ptr_nxt_s = ptr_nxt_s;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (adv_en && (|gnt)) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/tomasulo_cdb_arb.sv
// CDB arbiter: grants writeback slots to stations, owns the slot schedule and
// registers the functional-unit result onto the broadcast bus.
module tomasulo_cdb_arb
    import tomasulo_pkg::*;
#(
    parameter int                RS_N        = 2,
    parameter int                SCH_N       = CDB_SCH_N,
    parameter logic [4*RS_N-1:0] LATENCY_VEC = {4'd3, 4'd2}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RS_N-1:0]      cdb_req,
    output logic [RS_N-1:0]      cdb_gnt,
    output logic [SCH_N-1:0]     sch_r,
    input  logic [RS_N-1:0]      fu_vld,
    input  fu_res_t [RS_N-1:0]   fu_res,
    output cdb_t                 cdb_r,
    output logic [CDB_ERR_W-1:0] err_r
);

    logic [RS_N-1:0]      blk_s;
    logic [RS_N-1:0]      qual_s;
    logic [RS_N-1:0]      gnt_s;
    logic [SCH_N-1:0]     sch_set_s;
    cdb_t                 cdb_nxt_s;
    logic                 any_vld_s;
    logic                 multi_vld_s;
    logic [CDB_ERR_W-1:0] err_nxt_s;

    // A station is blocked when its writeback slot is already reserved.
    always_comb begin
        blk_s = '0;
        for (int i = 0; i < RS_N; i++) begin
            blk_s[i] = |(sch_r & (SCH_N'(1'b1) << LATENCY_VEC[4*i +: 4]));
        end
    end

    assign qual_s  = cdb_req & ~blk_s & {RS_N{~rst}};
    assign cdb_gnt = gnt_s;

    tomasulo_rr_arb #(
        .N (RS_N)
    ) u_rr_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (qual_s),
        .adv_en (1'b1),
        .gnt    (gnt_s)
    );

    // Reservation bit lands at L-1 because the whole schedule shifts on the same edge.
    always_comb begin
        sch_set_s = '0;
        for (int i = 0; i < RS_N; i++) begin
            if (gnt_s[i]) begin
                sch_set_s = sch_set_s | (SCH_N'(1'b1) << (LATENCY_VEC[4*i +: 4] - 4'd1));
            end else begin
                sch_set_s = sch_set_s;
            end
        end
    end

    // Lowest-index valid FU drives the bus payload.
    always_comb begin
        cdb_nxt_s     = '0;
        cdb_nxt_s.vld = |fu_vld;
        for (int i = RS_N - 1; i >= 0; i--) begin
            if (fu_vld[i]) begin
                cdb_nxt_s.tag   = fu_res[i].tag;
                cdb_nxt_s.wdata = fu_res[i].wdata;
            end else begin
                cdb_nxt_s = cdb_nxt_s;
            end
        end
    end

    assign any_vld_s   = |fu_vld;
    assign multi_vld_s = popcnt8(8'(fu_vld)) > 4'd1;
    assign err_nxt_s   = err_r | {sch_r[1] & ~any_vld_s,
                                  any_vld_s & ~sch_r[1],
                                  multi_vld_s};

    // Schedule, broadcast and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sch_r <= '0;
            cdb_r <= '0;
            err_r <= '0;
        end else begin
            sch_r <= (sch_r >> 1) | sch_set_s;
            cdb_r <= cdb_nxt_s;
            err_r <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_tomasulo_cdb_arb.sv
// Self-checking bench for tomasulo_cdb_arb with a CDB result scoreboard.
module tb_tomasulo_cdb_arb;
    import tomasulo_pkg::*;

    localparam int              RS_N    = 2;
    localparam int              SCH_N   = 8;
    localparam logic [7:0]      LAT_VEC = {4'd3, 4'd2};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    cdb_req;
    logic [1:0]    cdb_gnt;
    logic [7:0]    sch_r;
    logic [1:0]    fu_vld;
    fu_res_t [1:0] fu_res;
    cdb_t          cdb_r;
    logic [2:0]    err_r;

    int   n_cmp = 0;
    int   n_bad = 0;
    cdb_t exp_q[$];
    int   lat[2] = '{2, 3};

    always #5 clk = ~clk;

    tomasulo_cdb_arb #(
        .RS_N        (RS_N),
        .SCH_N       (SCH_N),
        .LATENCY_VEC (LAT_VEC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cdb_req (cdb_req),
        .cdb_gnt (cdb_gnt),
        .sch_r   (sch_r),
        .fu_vld  (fu_vld),
        .fu_res  (fu_res),
        .cdb_r   (cdb_r),
        .err_r   (err_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        cdb_req = 2'b00;
        fu_vld  = 2'b00;
        fu_res  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        cdb_req = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b00) begin
            n_bad++; $display("FAIL reset_gnt_in_rst got=%b want=00", cdb_gnt);
        end
        cdb_req = 2'b00;
        rst     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_cmp++;
            if (sch_r !== 8'h00) begin
                n_bad++; $display("FAIL reset_sch cyc=%0d got=%b want=0", k, sch_r);
            end
            n_cmp++;
            if (cdb_r.vld !== 1'b0) begin
                n_bad++; $display("FAIL reset_vld cyc=%0d got=%b want=0", k, cdb_r.vld);
            end
            n_cmp++;
            if (err_r !== 3'b000) begin
                n_bad++; $display("FAIL reset_err cyc=%0d got=%b want=000", k, err_r);
            end
            n_cmp++;
            if (cdb_gnt !== 2'b00) begin
                n_bad++; $display("FAIL reset_gnt cyc=%0d got=%b want=00", k, cdb_gnt);
            end
        end
    endtask

    task automatic test_single_grant();
        cdb_t e;
        do_reset();
        cdb_req = 2'b10;
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b10) begin
            n_bad++; $display("FAIL sg_gnt got=%b want=10", cdb_gnt);
        end
        tick();
        cdb_req = 2'b00;
        n_cmp++;
        if (sch_r !== 8'b0000_0100) begin
            n_bad++; $display("FAIL sg_sch_t1 got=%b want=00000100", sch_r);
        end
        tick();
        n_cmp++;
        if (sch_r !== 8'b0000_0010) begin
            n_bad++; $display("FAIL sg_sch_t2 got=%b want=00000010", sch_r);
        end
        fu_vld          = 2'b10;
        fu_res[1].tag   = 6'd5;
        fu_res[1].wdata = 32'h0000_CAFE;
        e.vld = 1'b1; e.tag = 6'd5; e.wdata = 32'h0000_CAFE;
        exp_q.push_back(e);
        tick();
        drive_idle();
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++; $display("FAIL sg_cdb scoreboard empty got=%h", cdb_r);
        end else begin
            e = exp_q.pop_front();
            if (cdb_r !== e) begin
                n_bad++; $display("FAIL sg_cdb got=%h want=%h", cdb_r, e);
            end
        end
        n_cmp++;
        if (err_r !== 3'b000) begin
            n_bad++; $display("FAIL sg_err got=%b want=000", err_r);
        end
        tick();
        n_cmp++;
        if (cdb_r.vld !== 1'b0 || sch_r !== 8'h00) begin
            n_bad++; $display("FAIL sg_idle got vld=%b sch=%b want vld=0 sch=0", cdb_r.vld, sch_r);
        end
    endtask

    task automatic test_contention();
        logic [7:0] msch;
        logic [7:0] mset;
        int         mptr;
        bit         pv[16];
        int         pst[16];
        tag_t       ptag[16];
        word_t      pdat[16];
        bit         drove;
        logic [1:0] req;
        logic [1:0] qual;
        logic [1:0] eg;
        int         s;
        int         slot;
        cdb_t       e;
        do_reset();
        msch = 8'h00;
        mptr = 0;
        for (int k = 0; k < 16; k++) begin
            pv[k] = 1'b0; pst[k] = 0; ptag[k] = '0; pdat[k] = '0;
        end
        for (int c = 0; c < 48; c++) begin
            fu_vld = 2'b00;
            fu_res = '0;
            drove  = 1'b0;
            slot   = c % 16;
            if (pv[slot]) begin
                s               = pst[slot];
                fu_vld[s]       = 1'b1;
                fu_res[s].tag   = ptag[slot];
                fu_res[s].wdata = pdat[slot];
                e.vld = 1'b1; e.tag = ptag[slot]; e.wdata = pdat[slot];
                exp_q.push_back(e);
                pv[slot] = 1'b0;
                drove    = 1'b1;
            end
            req     = (c < 24) ? 2'b11 : 2'($urandom_range(0, 3));
            cdb_req = req;
            for (int i = 0; i < 2; i++) begin
                qual[i] = req[i] & ~msch[lat[i]];
            end
            eg = 2'b00;
            for (int k = 0; k < 2; k++) begin
                s = (mptr + k) % 2;
                if (qual[s] && eg == 2'b00) eg[s] = 1'b1;
            end
            #1;
            n_cmp++;
            if (cdb_gnt !== eg) begin
                n_bad++; $display("FAIL ct_gnt cyc=%0d req=%b got=%b want=%b", c, req, cdb_gnt, eg);
            end
            mset = 8'h00;
            for (int i = 0; i < 2; i++) begin
                if (eg[i]) begin
                    slot       = (c + lat[i] - 1) % 16;
                    pv[slot]   = 1'b1;
                    pst[slot]  = i;
                    ptag[slot] = 6'($urandom);
                    pdat[slot] = $urandom;
                    mset       = 8'h01 << (lat[i] - 1);
                    mptr       = (i + 1) % 2;
                end
            end
            msch = (msch >> 1) | mset;
            tick();
            n_cmp++;
            if (sch_r !== msch) begin
                n_bad++; $display("FAIL ct_sch cyc=%0d got=%b want=%b", c, sch_r, msch);
            end
            n_cmp++;
            if (cdb_r.vld !== drove) begin
                n_bad++; $display("FAIL ct_vld cyc=%0d got=%b want=%b", c, cdb_r.vld, drove);
            end
            if (drove) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (cdb_r !== e) begin
                    n_bad++; $display("FAIL ct_cdb cyc=%0d got=%h want=%h", c, cdb_r, e);
                end
            end
            n_cmp++;
            if (err_r !== 3'b000) begin
                n_bad++; $display("FAIL ct_err cyc=%0d got=%b want=000", c, err_r);
            end
        end
        drive_idle();
    endtask

    task automatic test_slot_blocking();
        cdb_t e;
        do_reset();
        cdb_req = 2'b10;
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b10) begin
            n_bad++; $display("FAIL sb_gnt_t0 got=%b want=10", cdb_gnt);
        end
        tick();
        cdb_req = 2'b01;
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b00 || sch_r !== 8'b0000_0100) begin
            n_bad++; $display("FAIL sb_blocked got gnt=%b sch=%b want gnt=00 sch=00000100", cdb_gnt, sch_r);
        end
        tick();
        fu_vld          = 2'b10;
        fu_res[1].tag   = 6'd7;
        fu_res[1].wdata = 32'h0000_1234;
        e.vld = 1'b1; e.tag = 6'd7; e.wdata = 32'h0000_1234;
        exp_q.push_back(e);
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b01) begin
            n_bad++; $display("FAIL sb_gnt_t2 got=%b want=01", cdb_gnt);
        end
        tick();
        cdb_req         = 2'b00;
        fu_res          = '0;
        fu_vld          = 2'b01;
        fu_res[0].tag   = 6'd9;
        fu_res[0].wdata = 32'h0000_BEEF;
        e = exp_q.pop_front();
        n_cmp++;
        if (cdb_r !== e) begin
            n_bad++; $display("FAIL sb_cdb1 got=%h want=%h", cdb_r, e);
        end
        e.vld = 1'b1; e.tag = 6'd9; e.wdata = 32'h0000_BEEF;
        exp_q.push_back(e);
        tick();
        drive_idle();
        e = exp_q.pop_front();
        n_cmp++;
        if (cdb_r !== e) begin
            n_bad++; $display("FAIL sb_cdb2 got=%h want=%h", cdb_r, e);
        end
        n_cmp++;
        if (err_r !== 3'b000) begin
            n_bad++; $display("FAIL sb_err got=%b want=000", err_r);
        end
    endtask

    task automatic test_errors();
        cdb_t e;
        do_reset();
        fu_vld          = 2'b01;
        fu_res[0].tag   = 6'd1;
        fu_res[0].wdata = 32'h0000_0011;
        e.vld = 1'b1; e.tag = 6'd1; e.wdata = 32'h0000_0011;
        exp_q.push_back(e);
        tick();
        n_cmp++;
        if (err_r !== 3'b010) begin
            n_bad++; $display("FAIL err_unsched got=%b want=010", err_r);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cdb_r !== e) begin
            n_bad++; $display("FAIL err_cdb_b got=%h want=%h", cdb_r, e);
        end
        fu_vld          = 2'b11;
        fu_res[0].tag   = 6'd2;
        fu_res[0].wdata = 32'h0000_0022;
        fu_res[1].tag   = 6'd3;
        fu_res[1].wdata = 32'h0000_0033;
        e.vld = 1'b1; e.tag = 6'd2; e.wdata = 32'h0000_0022;
        exp_q.push_back(e);
        tick();
        drive_idle();
        n_cmp++;
        if (err_r !== 3'b011) begin
            n_bad++; $display("FAIL err_collision got=%b want=011", err_r);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (cdb_r !== e) begin
            n_bad++; $display("FAIL err_cdb_prio got=%h want=%h", cdb_r, e);
        end
        do_reset();
        cdb_req = 2'b01;
        tick();
        cdb_req = 2'b00;
        n_cmp++;
        if (err_r !== 3'b000 || sch_r !== 8'b0000_0010) begin
            n_bad++; $display("FAIL err_pre_missing got err=%b sch=%b want err=000 sch=00000010", err_r, sch_r);
        end
        tick();
        n_cmp++;
        if (err_r !== 3'b100) begin
            n_bad++; $display("FAIL err_missing got=%b want=100", err_r);
        end
        repeat (3) tick();
        n_cmp++;
        if (err_r !== 3'b100) begin
            n_bad++; $display("FAIL err_sticky got=%b want=100", err_r);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cdb_req = 2'b10;
        tick();
        fu_vld          = 2'b01;
        fu_res[0].tag   = 6'd4;
        fu_res[0].wdata = 32'h0000_0044;
        tick();
        fu_vld = 2'b00;
        fu_res = '0;
        n_cmp++;
        if (sch_r !== 8'b0000_0110 || cdb_r.vld !== 1'b1) begin
            n_bad++; $display("FAIL ar_pre got sch=%b vld=%b want sch=00000110 vld=1", sch_r, cdb_r.vld);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sch_r !== 8'h00) begin
            n_bad++; $display("FAIL ar_sch got=%b want=0", sch_r);
        end
        n_cmp++;
        if (cdb_r !== '0) begin
            n_bad++; $display("FAIL ar_cdb got=%h want=0", cdb_r);
        end
        n_cmp++;
        if (err_r !== 3'b000 || cdb_gnt !== 2'b00) begin
            n_bad++; $display("FAIL ar_err_gnt got err=%b gnt=%b want 000/00", err_r, cdb_gnt);
        end
        exp_q.delete();
        drive_idle();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cdb_req = 2'b01;
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b01) begin
            n_bad++; $display("FAIL ar_gnt0 got=%b want=01", cdb_gnt);
        end
        tick();
        cdb_req = 2'b00;
        #3;
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        cdb_req = 2'b11;
        #1;
        n_cmp++;
        if (cdb_gnt !== 2'b01) begin
            n_bad++; $display("FAIL ar_ptr_clear got=%b want=01", cdb_gnt);
        end
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_single_grant();
        test_contention();
        test_slot_blocking();
        test_errors();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
